// File: rtl/twos_comp_serial_ctrl.sv
// Parallel-word wrapper around the bit-serial two's-complement core: clear, stream LSB-first, collect.
// Optional: define TWOS_CTRL_ZERO_SKIP_EN to bypass the core for a zero operand.
module twos_comp_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             core_clr,
  output logic             core_bit_in,
  input  logic             core_bit_out
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] rreg_q, rreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      rreg_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      rreg_q  <= rreg_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    rreg_d      = rreg_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    core_clr    = 1'b0;
    core_bit_in = 1'b0;
    case (state_q)
      IDLE: begin
        // Held low while reset is asserted so nothing upstream sees a phantom ready.
        in_ready = rst;
        if (in_valid && in_ready) begin
          sreg_d  = in_data;
          rreg_d  = '0;
          ovf_d   = (in_data == MOST_NEG);
          state_d = CLEAR;
`ifdef TWOS_CTRL_ZERO_SKIP_EN
          if (in_data == '0) state_d = DONE;
`endif
        end
      end
      CLEAR: begin
        core_clr = 1'b1;
        cnt_d    = '0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        core_bit_in = sreg_q[0];
        rreg_d      = {core_bit_out, rreg_q[WIDTH-1:1]};
        sreg_d      = sreg_q >> 1;
        cnt_d       = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_data = rreg_q;
  assign out_ovf  = ovf_q;

endmodule
